// File: rtl/jtag_master.sv
// jtag_master: host-side JTAG initiator driving a TAP through TCK/TMS/TDI.
// Accepts RESET / SCAN_IR / SCAN_DR / IDLE commands on a valid/ready port,
// returns captured TDO bits on a one-cycle rsp_valid strobe and mirrors the
// target TAP state in shadow_state.
// Ports: tclk/trst (sync active-high reset), cmd_* command port, rsp_* response,
//        busy, shadow_state, tck_o/tms_o/tdi_o/tdo_i JTAG pins.
// Optional: define JTAG_TRST_OUT_EN to add trst_o; RESET then pulses trst_o
//           for 2*DIV cycles followed by a single TMS=0 edge.
module jtag_master #(
   parameter int unsigned MAX_LEN = 32,
   parameter int unsigned DIV     = 2
) (
   input  logic                         tclk,
   input  logic                         trst,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic [1:0]                   cmd_type,
   input  logic [$clog2(MAX_LEN+1)-1:0] cmd_len,
   input  logic [MAX_LEN-1:0]           cmd_data,
   output logic                         rsp_valid,
   output logic [MAX_LEN-1:0]           rsp_data,
   output logic                         busy,
   output logic [3:0]                   shadow_state,
   output logic                         tck_o,
   output logic                         tms_o,
   output logic                         tdi_o,
   input  logic                         tdo_i
`ifdef JTAG_TRST_OUT_EN
   ,output logic                        trst_o
`endif
);

   localparam int unsigned LW = $clog2(MAX_LEN + 1);
   localparam int unsigned IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int unsigned EW = $clog2(MAX_LEN + 8);
   localparam int unsigned DW = $clog2(2 * DIV + 1);

   localparam logic [1:0] CMD_RESET = 2'd0, CMD_SCAN_IR = 2'd1,
                          CMD_SCAN_DR = 2'd2, CMD_IDLE = 2'd3;

   localparam logic [3:0] TLR = 4'd0, RTI = 4'd1, SEL_DR = 4'd2, CAP_DR = 4'd3,
                          SHIFT_DR = 4'd4, EXIT1_DR = 4'd5, PAUSE_DR = 4'd6,
                          EXIT2_DR = 4'd7, UPD_DR = 4'd8, SEL_IR = 4'd9,
                          CAP_IR = 4'd10, SHIFT_IR = 4'd11, EXIT1_IR = 4'd12,
                          PAUSE_IR = 4'd13, EXIT2_IR = 4'd14, UPD_IR = 4'd15;

   typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_TCK_LO, ST_TCK_HI, ST_DONE} state_t;

   state_t state_q, state_nx;

   logic [1:0]         typ_q, typ_n;
   logic [LW-1:0]      len_q, len_n, clen;
   logic [MAX_LEN-1:0] data_q, data_n, cap_q, cap_n, rsp_data_n;
   logic               pre_q, pre_n, sh_q, sh_n;
   logic [IW-1:0]      sidx_q, sidx_n;
   logic [EW-1:0]      edge_q, edge_n;
   logic [DW-1:0]      div_q, div_n;
   logic               tck_n, tms_n, tdi_n, cmd_ready_n, busy_n, rsp_valid_n;
   logic [3:0]         shadow_n;
   logic               hold_q, hold_n;
   logic               n_tms, n_tdi, n_sh;
   logic [IW-1:0]      n_sidx;
   logic               lo_end, hi_end, hold_end, last;
   int                 nidx, hd, tot, k, s;

   // Standard 16-state TAP transition function
   function automatic logic [3:0] tap_next(input logic [3:0] st, input logic tms);
      case (st)
         TLR:      tap_next = tms ? TLR      : RTI;
         RTI:      tap_next = tms ? SEL_DR   : RTI;
         SEL_DR:   tap_next = tms ? SEL_IR   : CAP_DR;
         CAP_DR:   tap_next = tms ? EXIT1_DR : SHIFT_DR;
         SHIFT_DR: tap_next = tms ? EXIT1_DR : SHIFT_DR;
         EXIT1_DR: tap_next = tms ? UPD_DR   : PAUSE_DR;
         PAUSE_DR: tap_next = tms ? EXIT2_DR : PAUSE_DR;
         EXIT2_DR: tap_next = tms ? UPD_DR   : SHIFT_DR;
         UPD_DR:   tap_next = tms ? SEL_DR   : RTI;
         SEL_IR:   tap_next = tms ? TLR      : CAP_IR;
         CAP_IR:   tap_next = tms ? EXIT1_IR : SHIFT_IR;
         SHIFT_IR: tap_next = tms ? EXIT1_IR : SHIFT_IR;
         EXIT1_IR: tap_next = tms ? UPD_IR   : PAUSE_IR;
         PAUSE_IR: tap_next = tms ? EXIT2_IR : PAUSE_IR;
         EXIT2_IR: tap_next = tms ? UPD_IR   : SHIFT_IR;
         default:  tap_next = tms ? SEL_DR   : RTI;
      endcase
   endfunction

   assign clen = (cmd_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : cmd_len;

   // Edge bookkeeping: header length, total edges, phase ends of the TCK divider
   always_comb begin
      hd   = (typ_q == CMD_SCAN_IR) ? 4 : 3;
      nidx = (state_q == ST_LOAD) ? 0 : int'(edge_q) + 1;
      case (typ_q)
`ifdef JTAG_TRST_OUT_EN
         CMD_RESET: tot = 1;
`else
         CMD_RESET: tot = 6;
`endif
         CMD_IDLE:  tot = int'(pre_q) + int'(len_q);
         default:   tot = int'(pre_q) + hd + int'(len_q) + 2;
      endcase
      last     = (int'(edge_q) == tot - 1);
      hold_end = hold_q && (div_q == DW'(2 * DIV - 1));
      lo_end   = !hold_q && (div_q == DW'(DIV - 1));
      hi_end   = (div_q == DW'(DIV - 1));
   end

   // TMS/TDI and shift flags for the edge about to be driven (index nidx)
   always_comb begin
      n_tms  = 1'b0;
      n_tdi  = 1'b0;
      n_sh   = 1'b0;
      n_sidx = '0;
      k      = nidx - int'(pre_q);
      s      = k - hd;
      case (typ_q)
         CMD_RESET: begin
`ifndef JTAG_TRST_OUT_EN
            n_tms = (nidx < 5);
`endif
         end
         CMD_IDLE: n_tms = 1'b0;
         default: begin
            if (k < 0) begin
               n_tms = 1'b0;
            end else if (k < hd) begin
               n_tms = (typ_q == CMD_SCAN_DR) ? (k == 0) : (k < 2);
            end else if (s < int'(len_q)) begin
               n_sh   = 1'b1;
               n_sidx = IW'(s);
               n_tdi  = data_q[n_sidx];
               n_tms  = (s == int'(len_q) - 1);
            end else begin
               n_tms = (s == int'(len_q));
            end
         end
      endcase
   end

   // State register plus registered outputs and datapath
   always_ff @(posedge tclk) begin
      if (trst) begin
         state_q      <= ST_IDLE;
         typ_q        <= '0;
         len_q        <= '0;
         data_q       <= '0;
         pre_q        <= 1'b0;
         sh_q         <= 1'b0;
         sidx_q       <= '0;
         edge_q       <= '0;
         div_q        <= '0;
         cap_q        <= '0;
         hold_q       <= 1'b0;
         tck_o        <= 1'b0;
         tms_o        <= 1'b1;
         tdi_o        <= 1'b0;
         cmd_ready    <= 1'b1;
         busy         <= 1'b0;
         rsp_valid    <= 1'b0;
         rsp_data     <= '0;
         shadow_state <= TLR;
      end else begin
         state_q      <= state_nx;
         typ_q        <= typ_n;
         len_q        <= len_n;
         data_q       <= data_n;
         pre_q        <= pre_n;
         sh_q         <= sh_n;
         sidx_q       <= sidx_n;
         edge_q       <= edge_n;
         div_q        <= div_n;
         cap_q        <= cap_n;
         hold_q       <= hold_n;
         tck_o        <= tck_n;
         tms_o        <= tms_n;
         tdi_o        <= tdi_n;
         cmd_ready    <= cmd_ready_n;
         busy         <= busy_n;
         rsp_valid    <= rsp_valid_n;
         rsp_data     <= rsp_data_n;
         shadow_state <= shadow_n;
      end
   end

`ifdef JTAG_TRST_OUT_EN
   assign trst_o = hold_q;
`endif

   // Next-state logic; zero-length scans skip straight to DONE
   always_comb begin
      state_nx = state_q;
      case (state_q)
         ST_IDLE:
            if (cmd_valid)
               state_nx = ((cmd_type == CMD_SCAN_IR || cmd_type == CMD_SCAN_DR) && clen == '0)
                          ? ST_DONE : ST_LOAD;
         ST_LOAD:   state_nx = (tot == 0) ? ST_DONE : ST_TCK_LO;
         ST_TCK_LO: if (lo_end) state_nx = ST_TCK_HI;
         ST_TCK_HI: if (hi_end) state_nx = last ? ST_DONE : ST_TCK_LO;
         default:   state_nx = ST_IDLE;
      endcase
   end

   // Output / datapath next values
   always_comb begin
      typ_n       = typ_q;
      len_n       = len_q;
      data_n      = data_q;
      pre_n       = pre_q;
      sh_n        = sh_q;
      sidx_n      = sidx_q;
      edge_n      = edge_q;
      div_n       = div_q;
      cap_n       = cap_q;
      hold_n      = hold_q;
      tck_n       = tck_o;
      tms_n       = tms_o;
      tdi_n       = tdi_o;
      shadow_n    = shadow_state;
      cmd_ready_n = (state_nx == ST_IDLE);
      busy_n      = (state_nx != ST_IDLE);
      rsp_valid_n = (state_nx == ST_DONE);
      rsp_data_n  = rsp_data;
      if (state_nx == ST_DONE)
         rsp_data_n = (state_q == ST_IDLE) ? '0 : cap_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               typ_n  = cmd_type;
               len_n  = clen;
               data_n = cmd_data;
               pre_n  = (shadow_state == TLR) && (cmd_type != CMD_RESET);
               cap_n  = '0;
            end
         end
         ST_LOAD: begin
            edge_n = '0;
            div_n  = '0;
            tck_n  = 1'b0;
            tms_n  = n_tms;
            tdi_n  = n_tdi;
            sh_n   = n_sh;
            sidx_n = n_sidx;
`ifdef JTAG_TRST_OUT_EN
            if (typ_q == CMD_RESET) hold_n = 1'b1;
`endif
         end
         ST_TCK_LO: begin
            div_n = div_q + DW'(1);
            if (hold_end) begin
               hold_n = 1'b0;
               div_n  = '0;
            end else if (lo_end) begin
               // rising TCK edge: target samples TMS/TDI, we sample TDO
               tck_n    = 1'b1;
               div_n    = '0;
               shadow_n = tap_next(shadow_state, tms_o);
               if (sh_q) cap_n[sidx_q] = tdo_i;
            end
         end
         ST_TCK_HI: begin
            div_n = div_q + DW'(1);
            if (hi_end) begin
               tck_n = 1'b0;
               div_n = '0;
               if (!last) begin
                  edge_n = edge_q + EW'(1);
                  tms_n  = n_tms;
                  tdi_n  = n_tdi;
                  sh_n   = n_sh;
                  sidx_n = n_sidx;
               end else begin
                  tdi_n = 1'b0;
               end
            end
         end
         default: ;
      endcase
      if (hold_q) shadow_n = TLR;
   end

endmodule

// File: doc/jtag_master.md
Name: jtag_master

Overview:
- JTAG initiator that drives the TAP controller from the host side.
- Accepts scan commands (reset, IR scan, DR scan, idle clocking) on a valid/ready interface.
- Generates tck_o/tms_o/tdi_o, samples tdo_i and returns the captured bits on a one-cycle response strobe.
- Keeps a shadow copy of the target TAP state, updated with the standard 16-state transition function.

Parameters:
- MAX_LEN, 32, maximum scan length in bits; width of cmd_data/rsp_data.
- DIV, 2, tclk cycles per TCK half-period (legal range >=1).

Ports:
- tclk  input  1  system clock; all logic on its rising edge.
- trst  input  1  synchronous active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  master can accept a command.
- cmd_type  input  2  00 RESET, 01 SCAN_IR, 10 SCAN_DR, 11 IDLE.
- cmd_len  input  $clog2(MAX_LEN+1)  shift bits (scans) or TCK count (IDLE).
- cmd_data  input  MAX_LEN  TDI data, LSB shifted first.
- rsp_valid  output  1  one-cycle pulse at command completion.
- rsp_data  output  MAX_LEN  captured TDO bits.
- busy  output  1  command in progress.
- shadow_state  output  4  mirrored TAP state.
- tck_o  output  1  JTAG TCK.
- tms_o  output  1  JTAG TMS.
- tdi_o  output  1  JTAG TDI.
- tdo_i  input  1  JTAG TDO.

Behaviour:
- Reset values: tck_o=0, tms_o=1, tdi_o=0, cmd_ready=1, busy=0, rsp_valid=0, rsp_data=0, shadow_state=0 (TLR).
- Reset asserted mid-command aborts it immediately: no rsp_valid, same values as above on the next cycle.
- shadow_state encoding: 0 TLR, 1 RTI, 2 SEL_DR, 3 CAP_DR, 4 SHIFT_DR, 5 EXIT1_DR, 6 PAUSE_DR, 7 EXIT2_DR, 8 UPD_DR, 9 SEL_IR, 10 CAP_IR, 11 SHIFT_IR, 12 EXIT1_IR, 13 PAUSE_IR, 14 EXIT2_IR, 15 UPD_IR.
- shadow_state advances on each TCK rising edge using the current tms_o.
- FSM states: IDLE, LOAD, TCK_LO, TCK_HI, DONE.
- Handshake: cmd_ready=1 only in IDLE. Accept occurs on cmd_valid&cmd_ready; cmd fields are latched and busy=1 from the next cycle.
- Bit timing:
  - tms_o/tdi_o for a TCK period are driven while tck_o is low (set on accept+1, then on every falling edge).
  - tck_o stays low DIV cycles, then high DIV cycles.
  - tdo_i is sampled on the tclk cycle that tck_o rises, only on shift edges.
- Length handling: cmd_len > MAX_LEN is clamped to MAX_LEN. Scan with len=0 issues no TCK edges; rsp_valid fires one cycle after accept with rsp_data=0.
- Entry prefix: if shadow_state==TLR when a SCAN or IDLE command starts, one extra edge with TMS=0 is prepended.
- TMS sequences, per rising edge, starting from RTI:
  - SCAN_DR: 1,0,0, then len shift edges (TMS=0 except last=1), then 1,0.
  - SCAN_IR: 1,1,0,0, then len shift edges as above, then 1,0.
  - RESET: 1,1,1,1,1,0, valid from any state.
  - IDLE: len edges, TMS=0.
- Every command ends in RTI.
- TDI during shift edge i = cmd_data[i]. TDI outside shift edges = 0.
- rsp_data bit i = tdo_i sampled at shift edge i; bits >= len are 0. rsp_data holds until the next rsp_valid.
- Completion: DONE state is entered the cycle after the last falling edge. rsp_valid=1 for that single cycle, then the FSM returns to IDLE (cmd_ready=1 the following cycle).

Optional Feature:
- Macro: JTAG_TRST_OUT_EN.
- Defined:
  - Adds output trst_o (reset 0).
  - RESET command drives trst_o=1 with tck_o held low for 2*DIV cycles, then trst_o=0, then one edge with TMS=0.
  - shadow_state is forced to TLR while trst_o=1.
- Undefined: port absent; RESET uses the 5x TMS=1 plus 1x TMS=0 sequence.

Test Plan:
- Reset with DIV=1 -> tck_o=0, tms_o=1, cmd_ready=1, shadow_state=0; after 10 idle cycles still no TCK edges.
- First command SCAN_IR len=4 data=4'b1010, tdo_i=1 -> 11 rising edges with TMS 0,1,1,0,0,0,0,0,1,1,0; TDI on shift edges 0,1,0,1; rsp_data=0x0000000F; shadow_state=1.
- Bench 8-bit DR model (samples TDI on TCK rise, shifts TDO on fall, initial 0x00): SCAN_DR len=8 0xA5 -> rsp_data=0x00; then SCAN_DR len=8 0x3C -> rsp_data=0xA5.
- RESET from RTI with the existing tap module attached -> TMS 1,1,1,1,1,0; tap run_test_idle=1; shadow_state=1. With JTAG_TRST_OUT_EN, trst_o high 2 cycles (DIV=1) and tap test_logic_reset observed.
- SCAN_DR len=0 -> no TCK edge, rsp_valid one cycle after accept, rsp_data=0. SCAN_DR len=40 -> exactly 32 shift edges.
- trst asserted during SHIFT_DR of a len=16 scan -> next cycle tck_o=0, tms_o=1, cmd_ready=1, shadow_state=0, no rsp_valid.
